// File: rtl/line_clear_engine_if.sv
// Bus between a playfield owner and the line-clear engine: request side
// (start, map_in) and result side (map_out, status, score).
interface line_clear_engine_if #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int CELLW = 4
);
  logic                                  start;
  logic [ROWS-1:0][COLS-1:0][CELLW-1:0]  map_in;
  logic [ROWS-1:0][COLS-1:0][CELLW-1:0]  map_out;
  logic                                  busy;
  logic                                  done;
  logic [4:0]                            lines_cleared;
  logic [13:0]                           score;

  modport master (
    output start, map_in,
    input  map_out, busy, done, lines_cleared, score
  );

  modport slave (
    input  start, map_in,
    output map_out, busy, done, lines_cleared, score
  );
endinterface

// File: rtl/line_clear_engine.sv
// Removes full rows from a locked playfield one row per cycle, drops the
// survivors to the bottom, zero-fills the top and keeps a saturating score.
module line_clear_engine #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int CELLW = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic game_reset,
  line_clear_engine_if.slave bus
);
  localparam int IW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS + 1);

  typedef logic [COLS-1:0][CELLW-1:0] row_t;
  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_t;

  state_t           state_reg, state_next;
  row_t [ROWS-1:0]  work_reg, build_reg, build_next, map_out_reg;
  logic [IW-1:0]    rd_reg, wr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic [4:0]       lines_reg;
  logic [13:0]      score_reg, score_new;
  logic [14:0]      score_sum;
  logic             busy, done;

  logic clear;
  assign clear = !Reset || game_reset;

  row_t             cur_row;
  logic [COLS-1:0]  cell_set;
  logic             row_full, last_scan, last_fill;

  assign cur_row = work_reg[rd_reg];
  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_cell
      assign cell_set[gi] = |cur_row[gi];
    end
  endgenerate
  assign row_full  = &cell_set;
  assign last_scan = (rd_reg == '0);
  // After SCAN, wr points at the highest row still to be zero-filled.
  assign last_fill = (wr_reg == '0);

  function automatic logic [14:0] points(input logic [CW-1:0] k);
    case (k)
      CW'(0):  points = 15'd0;
      CW'(1):  points = 15'd1;
      CW'(2):  points = 15'd3;
      CW'(3):  points = 15'd5;
      default: points = 15'(k) << 1;
    endcase
  endfunction

  always_ff @(posedge Clk) begin
    if (clear) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (bus.start) state_next = SCAN;
      SCAN: if (last_scan) state_next = (count_next != '0) ? FILL : DONE;
      FILL: if (last_fill) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg != IDLE);
    done = (state_reg == DONE);
  end

  always_comb begin
    build_next = build_reg;
    count_next = count_reg;
    if (state_reg == SCAN) begin
      if (row_full) count_next = count_reg + 1'b1;
      else          build_next[wr_reg] = cur_row;
    end else if (state_reg == FILL) begin
      build_next[wr_reg] = '0;
    end
  end

  assign score_sum = {1'b0, score_reg} + points(count_next);
  assign score_new = (score_sum > 15'd9999) ? 14'd9999 : score_sum[13:0];

  always_ff @(posedge Clk) begin
    if (clear) begin
      map_out_reg <= '0;
      lines_reg   <= '0;
      score_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (bus.start) begin
          work_reg  <= bus.map_in;
          rd_reg    <= IW'(ROWS - 1);
          wr_reg    <= IW'(ROWS - 1);
          count_reg <= '0;
        end
        SCAN: begin
          rd_reg    <= rd_reg - 1'b1;
          if (!row_full) wr_reg <= wr_reg - 1'b1;
          count_reg <= count_next;
          build_reg <= build_next;
        end
        FILL: begin
          wr_reg    <= wr_reg - 1'b1;
          build_reg <= build_next;
        end
        default: ;
      endcase
      // Results land on the edge entering DONE so they are valid with done.
      if (state_next == DONE) begin
        map_out_reg <= build_next;
        lines_reg   <= 5'(count_next);
        score_reg   <= score_new;
      end
    end
  end

  assign bus.map_out       = map_out_reg;
  assign bus.lines_cleared = lines_reg;
  assign bus.score         = score_reg;
  assign bus.busy          = busy;
  assign bus.done          = done;
endmodule

// File: tb/tb_line_clear_engine.sv
// Directed plus randomized checks of line_clear_engine against a row-queue
// reference model of the compaction and score rules.
module tb_line_clear_engine;
  typedef logic [9:0][3:0]  row_t;
  typedef logic [19:0][9:0][3:0] map_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic game_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  map_t exp_map = '0;
  int   exp_lines = 0;
  int   exp_score = 0;

  line_clear_engine_if #(.ROWS(20), .COLS(10), .CELLW(4)) bus ();

  line_clear_engine #(.ROWS(20), .COLS(10), .CELLW(4)) dut (
    .Clk(Clk), .Reset(Reset), .game_reset(game_reset), .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk); #1; cyc++;
  endtask

  task automatic check(input string tag, input logic [799:0] got, input logic [799:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic bit is_full(input row_t r);
    for (int c = 0; c < 10; c++) if (r[c] == 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  // Survivors kept bottom-up in a queue, then stacked from the floor.
  function automatic void model(input map_t m, output map_t o, output int k);
    row_t q[$];
    for (int r = 19; r >= 0; r--) if (!is_full(m[r])) q.push_back(m[r]);
    o = '0;
    foreach (q[i]) o[19 - i] = q[i];
    k = 20 - q.size();
  endfunction

  function automatic int pts(input int k);
    case (k)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 2 * k;
    endcase
  endfunction

  function automatic map_t rand_map(input int pfull);
    map_t m;
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(99) < pfull) begin
        for (int c = 0; c < 10; c++) m[r][c] = 4'($urandom_range(15, 1));
      end else begin
        for (int c = 0; c < 10; c++) m[r][c] = 4'($urandom_range(15, 0));
        m[r][$urandom_range(9)] = 4'h0;
      end
    end
    return m;
  endfunction

  function automatic map_t four_full_map();
    map_t m = rand_map(0);
    int placed = 0;
    while (placed < 4) begin
      int r = $urandom_range(19);
      if (!is_full(m[r])) begin
        for (int c = 0; c < 10; c++) m[r][c] = 4'($urandom_range(15, 1));
        placed++;
      end
    end
    return m;
  endfunction

  task automatic check_idle_cleared(input string tag);
    check({tag, "_busy"}, 800'(bus.busy), 800'(0));
    check({tag, "_done"}, 800'(bus.done), 800'(0));
    check({tag, "_map"}, bus.map_out, '0);
    check({tag, "_lines"}, 800'(bus.lines_cleared), 800'(0));
    check({tag, "_score"}, 800'(bus.score), 800'(0));
    exp_map = '0; exp_lines = 0; exp_score = 0;
  endtask

  task automatic pulse_game_reset();
    game_reset = 1'b1; step(); game_reset = 1'b0;
    check_idle_cleared("game_reset");
  endtask

  // One full operation; noise scrambles map_in and pulses start while busy.
  task automatic run_op(input map_t m, input bit noise, input string tag);
    map_t em;
    int k, seen, done_cyc, last;
    model(m, em, k);
    last = 21 + k;
    bus.map_in = m; bus.start = 1'b1;
    cyc = 0; step(); bus.start = 1'b0;
    if (noise) bus.map_in = rand_map(50);
    seen = 0; done_cyc = -1;
    while (cyc <= last) begin
      check({tag, "_busy"}, 800'(bus.busy), 800'(1));
      if (cyc == 5) check({tag, "_hold_map"}, bus.map_out, exp_map);
      if (bus.done === 1'b1) begin
        seen++; done_cyc = cyc;
        if (seen == 1) begin
          exp_map = em; exp_lines = k;
          exp_score = (exp_score + pts(k) > 9999) ? 9999 : exp_score + pts(k);
          check({tag, "_map"}, bus.map_out, exp_map);
          check({tag, "_lines"}, 800'(bus.lines_cleared), 800'(exp_lines));
          check({tag, "_score"}, 800'(bus.score), 800'(exp_score));
        end
      end
      bus.start = (noise && $urandom_range(3) == 0) ? 1'b1 : 1'b0;
      step();
    end
    bus.start = 1'b0;
    check({tag, "_done_count"}, 800'(seen), 800'(1));
    check({tag, "_done_cycle"}, 800'(done_cyc), 800'(last));
    check({tag, "_idle_after"}, 800'(bus.busy), 800'(0));
    check({tag, "_stable_score"}, 800'(bus.score), 800'(exp_score));
    check({tag, "_stable_map"}, bus.map_out, exp_map);
  endtask

  task automatic abort_op(input bit use_game, input string tag);
    int seen = 0;
    bus.map_in = rand_map(40); bus.start = 1'b1;
    cyc = 0; step(); bus.start = 1'b0;
    while (cyc < 10) step();
    if (use_game) game_reset = 1'b1; else Reset = 1'b0;
    step();
    game_reset = 1'b0; Reset = 1'b1;
    check({tag, "_busy_c11"}, 800'(bus.busy), 800'(0));
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) seen++;
      step();
    end
    check({tag, "_no_done"}, 800'(seen), 800'(0));
    check_idle_cleared(tag);
  endtask

  initial begin
    map_t m;
    bus.start = 1'b0; bus.map_in = '0;
    Reset = 1'b0; step(); step();
    check_idle_cleared("reset");
    Reset = 1'b1; step();

    run_op('0, 1'b0, "empty");

    m = '0;
    for (int c = 0; c < 10; c++) m[19][c] = 4'h1;
    m[18][0] = 4'h3;
    run_op(m, 1'b0, "one_line");

    pulse_game_reset();
    m = '0;
    for (int r = 16; r < 20; r++) for (int c = 0; c < 10; c++) m[r][c] = 4'h2;
    m[15][9] = 4'h5;
    run_op(m, 1'b0, "four_lines");
    check("four_lines_score8", 800'(bus.score), 800'(8));

    m = '0;
    for (int c = 0; c < 10; c++) begin
      m[19][c] = 4'h7; m[17][c] = 4'h9;
      m[18][c] = (c % 2 == 1) ? 4'(c + 1) : 4'h0;
      m[16][c] = (c < 5) ? 4'hA : 4'h0;
    end
    run_op(m, 1'b0, "split_lines");

    m = '0;
    for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) m[r][c] = 4'hF;
    run_op(m, 1'b0, "all_full");

    for (int i = 0; i < 20; i++) run_op(rand_map($urandom_range(60)), 1'b1, "random");

    abort_op(1'b0, "abort_reset");
    run_op(rand_map(30), 1'b0, "refill");
    abort_op(1'b1, "abort_game");

    for (int i = 0; i < 1251; i++) run_op(four_full_map(), i[0], "sat");
    check("sat_final", 800'(bus.score), 800'(9999));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_clear_engine.md
LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

Interface
REQ-001 Parameter ROWS, 20, number of playfield rows; row 0 is the top row and row ROWS-1 is the bottom row.
REQ-002 Parameter COLS, 10, number of cells per row.
REQ-003 Parameter CELLW, 4, bits per cell; value 0 means empty and any nonzero value means occupied (colour code).
REQ-004 Clk  in  1  single clock; all state changes on the rising edge.
REQ-005 Reset  in  1  synchronous, active-low reset; Reset=0 sampled at a rising edge resets the block.
REQ-006 game_reset  in  1  synchronous, active-high new-game request.
REQ-007 start  in  1  one-cycle request to compact map_in; sampled only in IDLE.
REQ-008 map_in  in  [ROWS-1:0][COLS-1:0][CELLW-1:0]  locked playfield; sampled only in the cycle start is accepted.
REQ-009 map_out  out  [ROWS-1:0][COLS-1:0][CELLW-1:0]  compacted playfield; registered.
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle pulse marking that map_out, lines_cleared and score are updated.
REQ-012 lines_cleared  out  5  number of full rows removed by the last operation (0..ROWS).
REQ-013 score  out  14  accumulated game score, saturating at 9999.

Function
REQ-014 States: IDLE, SCAN, FILL, DONE; encoding is free.
REQ-015 IDLE with start=1: capture map_in into a work register, set rd=wr=ROWS-1, clear the count, then go to SCAN.
REQ-016 IDLE with start=0: hold all outputs.
REQ-017 SCAN: process one row per cycle for exactly ROWS cycles, with rd going from ROWS-1 down to 0.
REQ-018 SCAN, row rd full (all COLS cells nonzero): do not copy it, increment the count, decrement rd.
REQ-019 SCAN, row rd not full: copy work[rd] to build[wr], then decrement both rd and wr.
REQ-020 After the row-0 SCAN cycle: go to FILL if count>0, otherwise go directly to DONE.
REQ-021 FILL: write one all-zero row per cycle to build[wr] and decrement wr, for exactly count cycles, then go to DONE.
REQ-022 DONE, one cycle:
- map_out = build;
- lines_cleared = count;
- score += points(count);
- done=1;
- next state IDLE.
REQ-023 points(k): 0 for k=0, 1 for k=1, 3 for k=2, 5 for k=3, 2k for k>=4.
REQ-024 Score addition is computed at 15 bits and the result saturates at 9999; score never wraps.
REQ-025 Latency: with start accepted in cycle 0 and k rows cleared, done=1 in cycle 21+k exactly (ROWS=20).
REQ-026 busy=1 in cycles 1 through 21+k, and busy=0 in cycle 22+k.
REQ-027 start while busy=1 is ignored and is not queued.
REQ-028 start in the DONE cycle is ignored; start in the cycle after DONE is accepted, so back-to-back operations are possible.
REQ-029 map_out, lines_cleared and score change only in DONE, in Reset or in game_reset; they are stable from DONE until the next DONE.
REQ-030 Relative order of the surviving (non-full) rows is preserved; cell values are copied unchanged.
REQ-031 Full rows need not be contiguous; all ROWS rows full gives lines_cleared=ROWS and an all-zero map_out.
REQ-032 Changes on map_in after start is accepted have no effect on the operation in progress.

Reset
REQ-033 Reset=0: state IDLE; map_out all zero; lines_cleared=0; score=0; done=0; busy=0; work/build contents don't-care.
REQ-034 Reset mid-operation aborts the operation: no done pulse is produced and busy=0 in the cycle after the reset edge.
REQ-035 game_reset=1 (with Reset=1) has the same effect as Reset.
REQ-036 Reset takes priority over game_reset, and game_reset takes priority over start and DONE updates in the same cycle.

Verification
REQ-037 All-zero map_in, start in cycle 0 -> busy in cycles 1-21, done in cycle 21, lines_cleared=0, map_out all zero, score=0.
REQ-038 Row 19 all 4'h1 and row 18 = {cell0=4'h3, rest 0} -> done in cycle 22, lines_cleared=1, map_out row19 = old row18, rows 0-18 zero, score=1.
REQ-039 Rows 16-19 full and row 15 = 4'h5 in cell 9 -> done in cycle 25, lines_cleared=4, map_out row19 cell9=5 and all else zero, score=8.
REQ-040 Rows 19 and 17 full, row 18 = pattern A, row 16 = pattern B -> map_out row19=A, row18=B, rows 0-17 zero, lines_cleared=2, score +=3.
REQ-041 1250 consecutive 4-line clears -> score reaches 9999 and stays 9999 after a further clear; a start pulsed while busy produces no extra done.
REQ-042 Reset=0 in cycle 10 of SCAN -> busy=0 from cycle 11, no done pulse, score=0, map_out zero; repeat using game_reset=1 and expect the same result.
